flash_bus_bridge: RTL and testbench
===================================

Name: flash_bus_bridge

Overview:
- Upstream stage of the SPI flash controller.
- Synchronises the 6809 bus strobes (E, Q) into the clk domain and decodes a 4 KB flash window.
- Issues single-cycle read/write requests (12-bit address, write data) to the controller.
- Stretches the 6809 cycle via MRDY until read data returns, and drives read data onto the CPU bus until E falls.

Parameters:
- BASE_HI, 4'hE, address bits [15:12] that select the flash window (0xE000–0xEFFF).
- SYNC_STAGES, 2, flip-flop depth of the E/Q synchronisers (min 2).
- TIMEOUT_CYCLES, 1023, clk cycles to wait for i_done before forcing a bus release (optional feature only).

Ports:
- clk  input  1  system clock; must be ≥16× E frequency.
- reset  input  1  asynchronous, active-low reset.
- i_enable  input  1  6809 E strobe, asynchronous.
- i_Q  input  1  6809 Q strobe, asynchronous.
- i_ADDRESS_BUS  input  16  CPU address.
- i_DataBus  input  8  CPU write data.
- i_RW  input  1  1 = read, 0 = write.
- i_busy  input  1  controller transaction in progress.
- i_done  input  1  one-cycle pulse: controller finished; i_rdata valid.
- i_rdata  input  8  read data from controller.
- o_req_rd  output  1  one-cycle read request.
- o_req_wr  output  1  one-cycle write request.
- o_addr  output  12  latched flash address, i_ADDRESS_BUS[11:0].
- o_wdata  output  8  latched write data.
- o_DataBus  output  8  read data to CPU.
- o_DataBus_oe  output  1  CPU data bus drive enable.
- o_MemoryReady  output  1  MRDY to 6809; 0 = stretch.
- o_sel  output  1  current cycle hits the flash window.

Behaviour:

Reset and synchronisation:
- Reset (async, while reset=0):
  - o_MemoryReady=1; o_req_rd=0; o_req_wr=0; o_DataBus_oe=0; o_sel=0.
  - o_DataBus=0; o_addr=0; o_wdata=0; state=IDLE; timeout counter=0.
- E and Q pass through SYNC_STAGES flops, then one edge-detect flop; Q_rise, E_fall and E_sync are available.
- Address and i_RW are captured on Q_rise.
- A write-data shadow register loads i_DataBus every clk while E_sync=1; its value at E_fall is the write data.

States:
- IDLE:
  - On Q_rise with i_ADDRESS_BUS[15:12]==BASE_HI: latch o_addr and RW, o_sel<=1.
  - Read → RD_REQ, and o_MemoryReady<=0 on the same edge.
  - Write → WR_WAIT.
  - Outside the window: remain in IDLE, o_sel<=0.
- RD_REQ:
  - While i_busy=1: hold, MRDY stays 0.
  - When i_busy=0: o_req_rd=1 for exactly one cycle → RD_WAIT.
- RD_WAIT:
  - On i_done: o_DataBus<=i_rdata, o_DataBus_oe<=1, o_MemoryReady<=1 → RD_HOLD.
- RD_HOLD:
  - On E_fall: o_DataBus_oe<=0, o_sel<=0 → IDLE.
- WR_WAIT:
  - On E_fall: o_wdata<=shadow → WR_REQ.
- WR_REQ (posted write):
  - MRDY stays 1 unless a new window access arrives.
  - When i_busy=0: o_req_wr=1 for one cycle → IDLE.

Boundary conditions:
- A window Q_rise arriving while in WR_REQ forces o_MemoryReady<=0.
  - The address and RW are latched into a one-entry pending slot.
  - After o_req_wr issues, the pending access starts directly in RD_REQ or WR_WAIT with MRDY still 0.
  - For a pending write, MRDY returns to 1 on entry to WR_WAIT.
- o_req_rd and o_req_wr are never both 1. Each is asserted only when i_busy=0.
- i_done outside RD_WAIT is ignored.
- A second i_done in RD_HOLD does not change o_DataBus.
- Reset mid-operation: outputs return to their reset values immediately. No request pulse is emitted after reset deasserts until a new Q_rise.
- Latency, read (controller idle): o_req_rd issues SYNC_STAGES+2 clk after raw Q rise. MRDY releases 1 clk after i_done.

Optional Feature:
- Macro: FLASH_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_REQ and RD_WAIT.
  - When it reaches TIMEOUT_CYCLES: o_DataBus<=8'hFF, o_DataBus_oe<=1, o_MemoryReady<=1 → RD_HOLD.
  - A sticky output o_timeout (1 bit, reset 0) is set; it clears only on reset.
  - The counter clears on entry to RD_REQ.
- Undefined: no counter and no o_timeout port; RD_WAIT waits indefinitely for i_done.

Test Plan:
- Read 0xE123, controller idle, i_rdata=8'h5A with i_done 40 clk after o_req_rd → expect:
  - one o_req_rd with o_addr=12'h123;
  - MRDY low until 1 clk after i_done;
  - o_DataBus=8'h5A with oe=1 until E_fall.
- Write 8'hC3 to 0xE7FF → expect o_req_wr pulse after E_fall with o_addr=12'h7FF, o_wdata=8'hC3; MRDY never low.
- Write to 0xE010 then immediate read of 0xE020, i_busy held 100 clk → expect:
  - MRDY low from the read's Q_rise;
  - o_req_wr before o_req_rd;
  - no overlap between the two request pulses.
- Access 0xD123 and 0xF000 → expect no requests, o_sel=0, MRDY=1, oe=0.
- Assert reset while in RD_WAIT → expect MRDY=1 and oe=0 asynchronously; no o_req pulse after release until a new window Q_rise.
- FLASH_BRIDGE_TIMEOUT_EN with TIMEOUT_CYCLES=15 and i_done never asserted → expect MRDY release 15 clk after RD_REQ entry, o_DataBus=8'hFF, o_timeout=1.

Source files
------------

// File: rtl/flash_bus_bridge.sv
// 6809 bus front end for the SPI flash controller: syncs E/Q, decodes the flash window, stretches MRDY on reads.
// Optional read timeout (forces 8'hFF and a bus release) is enabled by defining FLASH_BRIDGE_TIMEOUT_EN.
module flash_bus_bridge #(
  parameter logic [3:0] BASE_HI     = 4'hE,
  parameter int         SYNC_STAGES = 2
`ifdef FLASH_BRIDGE_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_Q,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic [7:0]  i_DataBus,
  input  logic        i_RW,
  input  logic        i_busy,
  input  logic        i_done,
  input  logic [7:0]  i_rdata,
  output logic        o_req_rd,
  output logic        o_req_wr,
  output logic [11:0] o_addr,
  output logic [7:0]  o_wdata,
  output logic [7:0]  o_DataBus,
  output logic        o_DataBus_oe,
  output logic        o_MemoryReady,
`ifdef FLASH_BRIDGE_TIMEOUT_EN
  output logic        o_timeout,
`endif
  output logic        o_sel
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_HOLD, WR_WAIT, WR_REQ} state_t;
  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_e_sync, r_q_sync;
  logic r_e_d, r_q_d;
  logic w_e_sync, w_q_sync, w_q_rise, w_e_fall, w_hit, w_win_q;

  // Q chain resets high so a Q already high at reset release is not seen as a new rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_sync <= '0;
      r_q_sync <= '1;
      r_e_d    <= 1'b0;
      r_q_d    <= 1'b1;
    end else begin
      r_e_sync <= {r_e_sync[SYNC_STAGES-2:0], i_enable};
      r_q_sync <= {r_q_sync[SYNC_STAGES-2:0], i_Q};
      r_e_d    <= w_e_sync;
      r_q_d    <= w_q_sync;
    end
  end

  assign w_e_sync = r_e_sync[SYNC_STAGES-1];
  assign w_q_sync = r_q_sync[SYNC_STAGES-1];
  assign w_q_rise = w_q_sync & ~r_q_d;
  assign w_e_fall = ~w_e_sync & r_e_d;
  assign w_hit    = (i_ADDRESS_BUS[15:12] == BASE_HI);
  assign w_win_q  = w_q_rise & w_hit;

  logic        r_mrdy, r_oe, r_sel, r_pend_vld, r_pend_rw;
  logic [7:0]  r_dout, r_wdata, r_shadow;
  logic [11:0] r_addr, r_pend_addr;
  logic        w_mrdy_nxt, w_oe_nxt, w_sel_nxt, w_pend_vld_nxt, w_pend_rw_nxt;
  logic [7:0]  w_dout_nxt, w_wdata_nxt;
  logic [11:0] w_addr_nxt, w_pend_addr_nxt;
  logic        w_req_rd, w_req_wr;

`ifdef FLASH_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout, w_to_fire;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_mrdy_nxt      = r_mrdy;
    w_oe_nxt        = r_oe;
    w_sel_nxt       = r_sel;
    w_dout_nxt      = r_dout;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_rw_nxt   = r_pend_rw;
    w_pend_addr_nxt = r_pend_addr;
    w_req_rd        = 1'b0;
    w_req_wr        = 1'b0;
    case (r_state)
      IDLE: if (w_q_rise) begin
        if (w_hit) begin
          w_addr_nxt = i_ADDRESS_BUS[11:0];
          w_sel_nxt  = 1'b1;
          if (i_RW) begin
            w_state_nxt = RD_REQ;
            w_mrdy_nxt  = 1'b0;
          end else begin
            w_state_nxt = WR_WAIT;
          end
        end else begin
          w_sel_nxt = 1'b0;
        end
      end
      RD_REQ: if (!i_busy) begin
        w_req_rd    = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: if (i_done) begin
        w_dout_nxt  = i_rdata;
        w_oe_nxt    = 1'b1;
        w_mrdy_nxt  = 1'b1;
        w_state_nxt = RD_HOLD;
      end
      RD_HOLD: if (w_e_fall) begin
        w_oe_nxt    = 1'b0;
        w_sel_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
      WR_WAIT: if (w_e_fall) begin
        w_wdata_nxt = r_shadow;
        w_state_nxt = WR_REQ;
      end
      WR_REQ: begin
        // A new window access behind a posted write is parked and the CPU stretched.
        if (w_win_q && !r_pend_vld) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_rw_nxt   = i_RW;
          w_pend_addr_nxt = i_ADDRESS_BUS[11:0];
          w_mrdy_nxt      = 1'b0;
          w_sel_nxt       = 1'b1;
        end
        if (!i_busy) begin
          w_req_wr = 1'b1;
          if (w_pend_vld_nxt) begin
            w_pend_vld_nxt = 1'b0;
            w_addr_nxt     = w_pend_addr_nxt;
            if (w_pend_rw_nxt) begin
              w_state_nxt = RD_REQ;
            end else begin
              w_state_nxt = WR_WAIT;
              w_mrdy_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = IDLE;
            w_sel_nxt   = 1'b0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef FLASH_BRIDGE_TIMEOUT_EN
    w_to_fire = ((r_state == RD_REQ && w_state_nxt == RD_REQ) ||
                 (r_state == RD_WAIT && w_state_nxt == RD_WAIT)) &&
                (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    if (w_to_fire) begin
      w_dout_nxt  = 8'hFF;
      w_oe_nxt    = 1'b1;
      w_mrdy_nxt  = 1'b1;
      w_state_nxt = RD_HOLD;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mrdy      <= 1'b1;
      r_oe        <= 1'b0;
      r_sel       <= 1'b0;
      r_dout      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_shadow    <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_rw   <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mrdy      <= w_mrdy_nxt;
      r_oe        <= w_oe_nxt;
      r_sel       <= w_sel_nxt;
      r_dout      <= w_dout_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_rw   <= w_pend_rw_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      if (w_e_sync) r_shadow <= i_DataBus;
    end
  end

`ifdef FLASH_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_state_nxt == RD_REQ && r_state != RD_REQ) r_cnt <= '0;
      else if (r_state == RD_REQ || r_state == RD_WAIT) r_cnt <= r_cnt + CW'(1);
      if (w_to_fire) r_timeout <= 1'b1;
    end
  end
  assign o_timeout = r_timeout;
`endif

  assign o_req_rd      = w_req_rd;
  assign o_req_wr      = w_req_wr;
  assign o_addr        = r_addr;
  assign o_wdata       = r_wdata;
  assign o_DataBus     = r_dout;
  assign o_DataBus_oe  = r_oe;
  assign o_MemoryReady = r_mrdy;
  assign o_sel         = r_sel;
endmodule

// File: tb/tb_flash_bus_bridge.sv
// Scoreboard bench for flash_bus_bridge: directed 6809 bus cycles, a controller responder and a request/data monitor.
module tb_flash_bus_bridge;
  logic        clk = 1'b0, reset = 1'b1;
  logic        i_enable = 1'b0, i_Q = 1'b0, i_RW = 1'b1, i_busy = 1'b0, i_done = 1'b0;
  logic [15:0] i_ADDRESS_BUS = '0;
  logic [7:0]  i_DataBus = '0, i_rdata = '0;
  logic        o_req_rd, o_req_wr, o_DataBus_oe, o_MemoryReady, o_sel;
  logic [11:0] o_addr;
  logic [7:0]  o_wdata, o_DataBus;
`ifdef FLASH_BRIDGE_TIMEOUT_EN
  logic        o_timeout;
`endif

  flash_bus_bridge #(.BASE_HI(4'hE), .SYNC_STAGES(2)
`ifdef FLASH_BRIDGE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(15)
`endif
  ) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_Q(i_Q),
    .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_DataBus(i_DataBus), .i_RW(i_RW),
    .i_busy(i_busy), .i_done(i_done), .i_rdata(i_rdata),
    .o_req_rd(o_req_rd), .o_req_wr(o_req_wr), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_DataBus(o_DataBus), .o_DataBus_oe(o_DataBus_oe), .o_MemoryReady(o_MemoryReady),
`ifdef FLASH_BRIDGE_TIMEOUT_EN
    .o_timeout(o_timeout),
`endif
    .o_sel(o_sel)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef enum int {EV_RD = 1, EV_WR = 2, EV_DATA = 3} ev_kind_t;
  typedef struct {ev_kind_t kind; logic [11:0] addr; logic [7:0] data;} ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [11:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every request pulse and every rising oe consumes one expected event.
  int   req_cnt = 0;
  logic prev_oe = 1'b0;
  ev_t  mon_e;
  always @(negedge clk) begin
    if (reset) begin
      if (o_req_rd || o_req_wr) begin
        req_cnt++;
        chk("req_exclusive", {31'b0, o_req_rd & o_req_wr}, 32'd0);
        chk("req_not_busy", {31'b0, i_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req: rd=%0b wr=%0b addr=%h with no request expected", o_req_rd, o_req_wr, o_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("req_kind", o_req_rd ? int'(EV_RD) : int'(EV_WR), int'(mon_e.kind));
          chk("req_addr", {20'b0, o_addr}, {20'b0, mon_e.addr});
          if (o_req_wr) chk("req_wdata", {24'b0, o_wdata}, {24'b0, mon_e.data});
        end
      end
      if (o_DataBus_oe && !prev_oe) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rdata: got %h with no read data expected", o_DataBus);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rdata_kind", int'(EV_DATA), int'(mon_e.kind));
          chk("rdata_value", {24'b0, o_DataBus}, {24'b0, mon_e.data});
        end
      end
    end
    prev_oe = o_DataBus_oe;
  end

  // MRDY-low tracking: run length of the most recent stretch and a sticky flag.
  int low_run = 0, last_low_len = 0;
  bit low_seen = 1'b0;
  always @(negedge clk) begin
    if (!reset) low_run = 0;
    else if (!o_MemoryReady) begin low_run++; low_seen = 1'b1; end
    else if (low_run != 0) begin last_low_len = low_run; low_run = 0; end
  end

  // Controller responder: i_done ~40 clk after each read request, then a stray second i_done.
  bit         resp_on = 1'b1;
  logic [7:0] rd_val = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (o_req_rd && resp_on && reset) begin
        repeat (39) @(negedge clk);
        chk("mrdy_low_before_done", {31'b0, o_MemoryReady}, 32'd0);
        i_rdata = rd_val; i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
        chk("mrdy_1clk_after_done", {31'b0, o_MemoryReady}, 32'd1);
        chk("oe_after_done", {31'b0, o_DataBus_oe}, 32'd1);
        i_rdata = ~rd_val; i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
        chk("hold_data_stable", {24'b0, o_DataBus}, {24'b0, rd_val});
      end
    end
  end

  // One 6809 cycle: address, Q rise, E rise, Q fall, wait for MRDY, E fall.
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           output logic sel_mid, output logic mrdy_mid);
    int n;
    i_ADDRESS_BUS = a; i_RW = rw; i_DataBus = 8'h00;
    repeat (2) @(negedge clk);
    i_Q = 1'b1;
    repeat (4) @(negedge clk);
    i_enable = 1'b1;
    if (!rw) i_DataBus = wd;
    sel_mid = o_sel; mrdy_mid = o_MemoryReady;
    repeat (4) @(negedge clk);
    i_Q = 1'b0;
    n = 0;
    while (!o_MemoryReady && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL mrdy_release_timeout: MRDY still 0 after %0d clk, expected release", n);
    end
    repeat (4) @(negedge clk);
    i_enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic s, m;
  int   rc;
  initial begin
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mrdy", {31'b0, o_MemoryReady}, 32'd1);
    chk("rst_reqs", {30'b0, o_req_rd, o_req_wr}, 32'd0);
    chk("rst_oe_sel", {30'b0, o_DataBus_oe, o_sel}, 32'd0);
    chk("rst_databus", {24'b0, o_DataBus}, 32'd0);
    chk("rst_addr_wdata", {12'b0, o_addr, o_wdata}, 32'd0);
`ifdef FLASH_BRIDGE_TIMEOUT_EN
    chk("rst_timeout", {31'b0, o_timeout}, 32'd0);
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Read 0xE123 -> 8'h5A
    rd_val = 8'h5A;
    push(EV_RD, 12'h123, 8'h00); push(EV_DATA, 12'h000, 8'h5A);
    bus_cycle(16'hE123, 1'b1, 8'h00, s, m);
    chk("rd_sel_mid", {31'b0, s}, 32'd1);
    chk("rd_mrdy_mid", {31'b0, m}, 32'd0);
    chk("rd_end_oe_sel", {30'b0, o_DataBus_oe, o_sel}, 32'd0);

    // Posted write 8'hC3 -> 0xE7FF
    low_seen = 1'b0;
    push(EV_WR, 12'h7FF, 8'hC3);
    bus_cycle(16'hE7FF, 1'b0, 8'hC3, s, m);
    repeat (4) @(negedge clk);
    chk("wr_mrdy_never_low", {31'b0, low_seen}, 32'd0);
    chk("wr_sel_mid", {31'b0, s}, 32'd1);
    chk("wr_drained", exp_q.size(), 32'd0);

    // Write 0xE010 then read 0xE020 behind a busy controller
    rd_val = 8'h96;
    push(EV_WR, 12'h010, 8'h3C); push(EV_RD, 12'h020, 8'h00); push(EV_DATA, 12'h000, 8'h96);
    fork
      begin
        @(posedge clk); #1 i_busy = 1'b1;
        repeat (100) @(posedge clk);
        #1 i_busy = 1'b0;
      end
    join_none
    bus_cycle(16'hE010, 1'b0, 8'h3C, s, m);
    chk("b2b_wr_mrdy_mid", {31'b0, m}, 32'd1);
    bus_cycle(16'hE020, 1'b1, 8'h00, s, m);
    chk("b2b_rd_mrdy_low", {31'b0, m}, 32'd0);
    repeat (4) @(negedge clk);
    chk("b2b_drained", exp_q.size(), 32'd0);

    // Outside the window
    rc = req_cnt;
    bus_cycle(16'hD123, 1'b1, 8'h00, s, m);
    chk("miss_d123_sel_mrdy", {30'b0, s, m}, 32'd1);
    bus_cycle(16'hF000, 1'b0, 8'h11, s, m);
    chk("miss_f000_sel_mrdy", {30'b0, s, m}, 32'd1);
    repeat (4) @(negedge clk);
    chk("miss_no_reqs", req_cnt - rc, 32'd0);
    chk("miss_oe", {31'b0, o_DataBus_oe}, 32'd0);

    // Reset while waiting for read data, with E and Q still high across release
    resp_on = 1'b0;
    push(EV_RD, 12'h456, 8'h00);
    i_ADDRESS_BUS = 16'hE456; i_RW = 1'b1;
    repeat (2) @(negedge clk);
    i_Q = 1'b1;
    repeat (4) @(negedge clk);
    i_enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_test_req_seen", exp_q.size(), 32'd0);
    chk("rdwait_mrdy_low", {31'b0, o_MemoryReady}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_mrdy", {31'b0, o_MemoryReady}, 32'd1);
    chk("async_rst_oe_sel", {30'b0, o_DataBus_oe, o_sel}, 32'd0);
    rc = req_cnt;
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_req_after_reset", req_cnt - rc, 32'd0);
    i_Q = 1'b0;
    repeat (4) @(negedge clk);
    i_enable = 1'b0;
    repeat (4) @(negedge clk);
    resp_on = 1'b1;
    rd_val = 8'h71;
    push(EV_RD, 12'h456, 8'h00); push(EV_DATA, 12'h000, 8'h71);
    bus_cycle(16'hE456, 1'b1, 8'h00, s, m);
    chk("post_rst_read_mrdy_mid", {31'b0, m}, 32'd0);

`ifdef FLASH_BRIDGE_TIMEOUT_EN
    // No i_done: timeout forces 8'hFF after 15 clk
    resp_on = 1'b0;
    push(EV_RD, 12'h0AA, 8'h00); push(EV_DATA, 12'h000, 8'hFF);
    bus_cycle(16'hE0AA, 1'b1, 8'h00, s, m);
    chk("timeout_stretch_len", last_low_len, 32'd15);
    chk("timeout_sticky", {31'b0, o_timeout}, 32'd1);
    resp_on = 1'b1;
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
